// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/control unit.
//   FWD_*      : EX operand forwarding select encodings
//   RSRC_LOAD  : ex_result_src value that marks a load
//   md_state_t : multi-cycle EX sequencing FSM states
//   fwd_sel()  : per-operand forwarding priority (MEM over WB, x0 never forwards)
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] RSRC_LOAD = 2'b01;

  typedef enum logic {
    IDLE,
    MD_WAIT
  } md_state_t;

  function automatic logic [1:0] fwd_sel(
    input logic       mem_we,
    input logic [4:0] mem_rd,
    input logic       wb_we,
    input logic [4:0] wb_rd,
    input logic [4:0] rs
  );
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
      return FWD_MEM;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
//   slave  : the hazard unit (consumes pipeline status, drives stall/flush/fwd/perf)
//   master : the pipeline side (drives status, consumes controls)
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // pipeline status
  logic [4:0]       id_rs1, id_rs2;
  logic             id_uses_rs1, id_uses_rs2;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic             ex_reg_write;
  logic [1:0]       ex_result_src;
  logic             ex_redirect;
  logic             ex_md_start;
  logic             md_done;
  logic [4:0]       mem_rd, wb_rd;
  logic             mem_reg_write, wb_reg_write;
  // controls
  logic             stall_pc, stall_ifid, flush_ifid;
  logic             stall_idex, flush_idex, bubble_exmem;
  logic [1:0]       fwd_a, fwd_b;
  logic             md_busy, md_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_result_src,
           ex_redirect, ex_md_start, md_done,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write,
    output stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex,
           bubble_exmem, fwd_a, fwd_b, md_busy, md_timeout,
           stall_cycles, flush_count
  );

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_result_src,
           ex_redirect, ex_md_start, md_done,
           mem_rd, wb_rd, mem_reg_write, wb_reg_write,
    input  stall_pc, stall_ifid, flush_ifid, stall_idex, flush_idex,
           bubble_exmem, fwd_a, fwd_b, md_busy, md_timeout,
           stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
//   clk, rst : clock, asynchronous active-high reset (clears count)
//   inc      : count this cycle
//   cnt      : current value, holds at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard/control unit.
//   clk, rst : clock, asynchronous active-high reset
//   hz       : pipeline status in; stall/flush controls, EX forwarding selects,
//              multi-cycle EX handshake status and perf counters out
// Priority of the stall/flush response: multi-cycle wait > redirect > load-use.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MD_TIMEOUT = 64
) (
  input  logic   clk,
  input  logic   rst,
  hazard_ctrl_if.slave hz
);

  localparam int TMO_W = $clog2(MD_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MD_TIMEOUT);

  md_state_t        state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             blk, blk_nxt;        // suppresses a stale start right after a timeout
  logic             md_wait, timeout_hit;
  logic             lu;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      blk     <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      blk     <= blk_nxt;
    end
  end

  // FSM next state; md_wait is the stall request of the multi-cycle unit
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    blk_nxt     = 1'b0;
    md_wait     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (hz.ex_md_start && !blk && !hz.md_done) begin
          md_wait     = 1'b1;
          state_nxt   = MD_WAIT;
          tmo_cnt_nxt = TMO_W'(1);
        end
      end
      MD_WAIT: begin
        if (hz.md_done) begin
          state_nxt = IDLE;
        end else if (tmo_cnt == TMO_MAX) begin
          // abort: release this cycle and block the still-present start once
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
          blk_nxt     = 1'b1;
        end else begin
          md_wait     = 1'b1;
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lu = hz.ex_reg_write && (hz.ex_result_src == RSRC_LOAD) && (hz.ex_rd != 5'd0) &&
              ((hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
               (hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd)));

  // Stall/flush response; rst forces every control low without waiting for a clock
  always_comb begin
    hz.stall_pc     = 1'b0;
    hz.stall_ifid   = 1'b0;
    hz.flush_ifid   = 1'b0;
    hz.stall_idex   = 1'b0;
    hz.flush_idex   = 1'b0;
    hz.bubble_exmem = 1'b0;
    if (!rst) begin
      if (md_wait) begin
        hz.stall_pc     = 1'b1;
        hz.stall_ifid   = 1'b1;
        hz.stall_idex   = 1'b1;
        hz.bubble_exmem = 1'b1;
      end else if (hz.ex_redirect) begin
        // stall_pc stays low so the redirect target loads
        hz.flush_ifid = 1'b1;
        hz.flush_idex = 1'b1;
      end else if (lu) begin
        hz.stall_pc   = 1'b1;
        hz.stall_ifid = 1'b1;
        hz.flush_idex = 1'b1;
      end
    end
  end

  assign hz.fwd_a = fwd_sel(hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd, hz.ex_rs1);
  assign hz.fwd_b = fwd_sel(hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd, hz.ex_rs2);

  // busy covers the held cycles in MD_WAIT, not the release cycle
  assign hz.md_busy    = !rst && (state == MD_WAIT) && !hz.md_done;
  assign hz.md_timeout = !rst && timeout_hit;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hz.stall_pc),
    .cnt (hz.stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hz.flush_ifid),
    .cnt (hz.flush_count)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CW  = 3;
  localparam int TMO = 6;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.CNT_W(CW), .MD_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    hz.id_rs1 = 5'd0;        hz.id_rs2 = 5'd0;
    hz.id_uses_rs1 = 1'b0;   hz.id_uses_rs2 = 1'b0;
    hz.ex_rs1 = 5'd0;        hz.ex_rs2 = 5'd0;   hz.ex_rd = 5'd0;
    hz.ex_reg_write = 1'b0;  hz.ex_result_src = 2'b00;
    hz.ex_redirect = 1'b0;   hz.ex_md_start = 1'b0; hz.md_done = 1'b0;
    hz.mem_rd = 5'd0;        hz.wb_rd = 5'd0;
    hz.mem_reg_write = 1'b0; hz.wb_reg_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu();
    hz.ex_reg_write = 1'b1; hz.ex_result_src = 2'b01; hz.ex_rd = 5'd5;
    hz.id_rs1 = 5'd5; hz.id_uses_rs1 = 1'b1; hz.id_rs2 = 5'd1; hz.id_uses_rs2 = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    #2;
    // reset state
    chk1("rst_stall_pc", hz.stall_pc, 1'b0);
    chk1("rst_flush_idex", hz.flush_idex, 1'b0);
    chk1("rst_md_busy", hz.md_busy, 1'b0);
    chk1("rst_md_timeout", hz.md_timeout, 1'b0);
    chk2("rst_fwd_a", hz.fwd_a, FWD_RF);
    chkc("rst_stall_cycles", hz.stall_cycles, 3'd0);
    chkc("rst_flush_count", hz.flush_count, 3'd0);
    tick(); tick();
    rst = 1'b0;

    // load-use: EX lw x5, ID add x6,x5,x1
    set_lu();
    #2;
    chk1("lu_stall_pc", hz.stall_pc, 1'b1);
    chk1("lu_stall_ifid", hz.stall_ifid, 1'b1);
    chk1("lu_flush_idex", hz.flush_idex, 1'b1);
    chk1("lu_flush_ifid", hz.flush_ifid, 1'b0);
    chk1("lu_stall_idex", hz.stall_idex, 1'b0);
    hz.ex_result_src = 2'b00;     // not a load: no bubble
    #1;
    chk1("nolu_alu_stall_pc", hz.stall_pc, 1'b0);
    hz.ex_result_src = 2'b01;
    #1;
    tick();
    clear_in();
    #2;
    chk1("lu_release", hz.stall_pc, 1'b0);
    chkc("lu_stall_cycles", hz.stall_cycles, 3'd1);

    // forwarding
    hz.mem_reg_write = 1'b1; hz.wb_reg_write = 1'b1;
    hz.mem_rd = 5'd7; hz.wb_rd = 5'd7; hz.ex_rs1 = 5'd7; hz.ex_rs2 = 5'd0;
    #2;
    chk2("fwd_a_mem", hz.fwd_a, 2'b10);
    chk2("fwd_b_x0", hz.fwd_b, 2'b00);
    hz.mem_rd = 5'd0;
    #2;
    chk2("fwd_a_wb", hz.fwd_a, 2'b01);
    hz.wb_reg_write = 1'b0;
    #2;
    chk2("fwd_a_none", hz.fwd_a, 2'b00);
    hz.ex_rs2 = 5'd9; hz.mem_rd = 5'd9;
    #2;
    chk2("fwd_b_mem", hz.fwd_b, 2'b10);
    clear_in();
    tick();

    // redirect overrides load-use
    set_lu();
    hz.ex_redirect = 1'b1;
    #2;
    chk1("rd_flush_ifid", hz.flush_ifid, 1'b1);
    chk1("rd_flush_idex", hz.flush_idex, 1'b1);
    chk1("rd_stall_pc", hz.stall_pc, 1'b0);
    chk1("rd_stall_ifid", hz.stall_ifid, 1'b0);
    tick();
    clear_in();
    #2;
    chkc("rd_flush_count", hz.flush_count, 3'd1);
    chkc("rd_stall_cycles", hz.stall_cycles, 3'd1);

    // multi-cycle op, done on the 6th cycle (cycles 0..4 stalled)
    hz.ex_md_start = 1'b1;
    hz.ex_redirect = 1'b1;        // redirect must wait for release
    #2;
    chk1("md0_stall_pc", hz.stall_pc, 1'b1);
    chk1("md0_stall_idex", hz.stall_idex, 1'b1);
    chk1("md0_bubble", hz.bubble_exmem, 1'b1);
    chk1("md0_flush_ifid", hz.flush_ifid, 1'b0);
    chk1("md0_md_busy", hz.md_busy, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      chk1("mdN_stall_pc", hz.stall_pc, 1'b1);
      chk1("mdN_md_busy", hz.md_busy, 1'b1);
    end
    tick();
    hz.md_done = 1'b1;
    #2;
    chk1("mddone_stall_pc", hz.stall_pc, 1'b0);
    chk1("mddone_stall_idex", hz.stall_idex, 1'b0);
    chk1("mddone_bubble", hz.bubble_exmem, 1'b0);
    chk1("mddone_md_busy", hz.md_busy, 1'b0);
    chk1("mddone_flush_ifid", hz.flush_ifid, 1'b1);
    tick();
    clear_in();
    #2;
    chk1("mdpost_md_busy", hz.md_busy, 1'b0);
    chkc("md_stall_cycles", hz.stall_cycles, 3'd6);
    chkc("md_flush_count", hz.flush_count, 3'd2);

    // timeout: start held, md_done never comes; MD_WAIT cycles 1..6, abort in 6
    hz.ex_md_start = 1'b1;
    #2;
    chk1("tmo0_stall_pc", hz.stall_pc, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      #1;
      chk1("tmoN_md_busy", hz.md_busy, 1'b1);
      chk1("tmoN_md_timeout", hz.md_timeout, 1'b0);
    end
    tick();
    #1;
    chk1("tmo_pulse", hz.md_timeout, 1'b1);
    chk1("tmo_release_stall_pc", hz.stall_pc, 1'b0);
    chk1("tmo_release_stall_idex", hz.stall_idex, 1'b0);
    tick();
    #1;
    chk1("tmo_ignore_stall_pc", hz.stall_pc, 1'b0);
    chk1("tmo_ignore_md_busy", hz.md_busy, 1'b0);
    chk1("tmo_pulse_end", hz.md_timeout, 1'b0);
    chkc("tmo_stall_sat", hz.stall_cycles, 3'd7);
    tick();
    #1;
    chk1("tmo_reenter_stall_pc", hz.stall_pc, 1'b1);
    tick();
    #1;
    chk1("rerun_md_busy", hz.md_busy, 1'b1);
    chkc("sat_hold", hz.stall_cycles, 3'd7);

    // asynchronous reset in MD_WAIT, start still asserted
    rst = 1'b1;
    #1;
    chk1("arst_stall_pc", hz.stall_pc, 1'b0);
    chk1("arst_stall_idex", hz.stall_idex, 1'b0);
    chk1("arst_md_busy", hz.md_busy, 1'b0);
    chkc("arst_stall_cycles", hz.stall_cycles, 3'd0);
    chkc("arst_flush_count", hz.flush_count, 3'd0);
    tick();
    clear_in();
    rst = 1'b0;

    // md_done in IDLE without a start is ignored
    hz.md_done = 1'b1;
    #2;
    chk1("idle_done_stall_pc", hz.stall_pc, 1'b0);
    tick();
    #1;
    chk1("idle_done_md_busy", hz.md_busy, 1'b0);
    clear_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
